// File: rtl/fetch_stage.sv
// MIPS F stage: PC register, combinational instruction ROM, F/D pipeline register (1-cycle F->D).
// Stall holds PC and F/D; ExcReq overrides Stall; ERet and Normal loads only when not stalled.
module fetch_stage #(
  parameter logic [31:0]            RESET_PC  = 32'h0000_3000,
  parameter logic [31:0]            TEXT_BASE = 32'h0000_3000,
  parameter int                     IM_DEPTH  = 4096,
  parameter logic [31:0]            EXC_ENTRY = 32'h0000_4180,
  parameter logic [IM_DEPTH*32-1:0] IM_INIT   = '0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] NPCOut,
  input  logic [31:0] JRTarget,
  input  logic        BranchD,
  input  logic        ExcReq,
  input  logic        ERet,
  input  logic [31:0] EPC,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PC4D,
  output logic [4:0]  ExcCodeD,
  output logic        BDSlotD
);

  localparam int          AW       = $clog2(IM_DEPTH);
  localparam logic [31:0] IM_BYTES = 32'(4 * IM_DEPTH);
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  logic [31:0] rom [IM_DEPTH];

  for (genvar i = 0; i < IM_DEPTH; i++) begin : g_rom
    assign rom[i] = IM_INIT[i*32 +: 32];
  end

  logic [31:0]   offset;
  logic [31:0]   pc_plus4;
  logic [31:0]   pc_next;
  logic [31:0]   instr_f;
  logic [AW-1:0] idx;
  logic          adel;

  // Addresses below TEXT_BASE wrap to huge offsets, so one unsigned compare covers both bounds.
  always_comb begin
    offset   = PCF - TEXT_BASE;
    pc_plus4 = PCF + 32'd4;
    adel     = (PCF[1:0] != 2'b00) || (offset >= IM_BYTES);
    idx      = adel ? '0 : offset[AW+1:2];
    instr_f  = adel ? 32'h0 : rom[idx];
    case (PCSrc)
      2'b01:   pc_next = NPCOut;
      2'b10:   pc_next = JRTarget;
      default: pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      PCF      <= RESET_PC;
      InstrD   <= 32'h0;
      PCD      <= 32'h0;
      PC4D     <= 32'h0;
      ExcCodeD <= 5'd0;
      BDSlotD  <= 1'b0;
    end else if (ExcReq) begin
      PCF      <= EXC_ENTRY;
      InstrD   <= 32'h0;
      PCD      <= EXC_ENTRY;
      PC4D     <= EXC_ENTRY + 32'd4;
      ExcCodeD <= 5'd0;
      BDSlotD  <= 1'b0;
    end else if (!Stall) begin
      if (ERet) begin
        PCF      <= EPC;
        InstrD   <= 32'h0;
        PCD      <= EPC;
        PC4D     <= EPC + 32'd4;
        ExcCodeD <= 5'd0;
        BDSlotD  <= 1'b0;
      end else begin
        PCF      <= pc_next;
        InstrD   <= instr_f;
        PCD      <= PCF;
        PC4D     <= pc_plus4;
        ExcCodeD <= adel ? EXC_ADEL : 5'd0;
        BDSlotD  <= BranchD;
      end
    end
  end

endmodule
